// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 scan-code decoder.
// Optional feature macro: PS2_ASCII_EN (shift tracking and ASCII lookup).
package ps2_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK
   } ps2_dec_state_t;

   localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
   localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

`ifdef PS2_ASCII_EN
   typedef struct packed {
      logic       shift;
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_key_t;

   // Set-2 make code to ASCII; letters follow shift, digits do not.
   function automatic logic [7:0] ps2_ascii(input logic [7:0] code, input logic shift);
      logic [7:0] ch;
      ch = 8'h00;
      case (code)
         8'h1C: ch = "a";
         8'h32: ch = "b";
         8'h21: ch = "c";
         8'h23: ch = "d";
         8'h24: ch = "e";
         8'h2B: ch = "f";
         8'h34: ch = "g";
         8'h33: ch = "h";
         8'h43: ch = "i";
         8'h3B: ch = "j";
         8'h42: ch = "k";
         8'h4B: ch = "l";
         8'h3A: ch = "m";
         8'h31: ch = "n";
         8'h44: ch = "o";
         8'h4D: ch = "p";
         8'h15: ch = "q";
         8'h2D: ch = "r";
         8'h1B: ch = "s";
         8'h2C: ch = "t";
         8'h3C: ch = "u";
         8'h2A: ch = "v";
         8'h1D: ch = "w";
         8'h22: ch = "x";
         8'h35: ch = "y";
         8'h1A: ch = "z";
         8'h45: ch = "0";
         8'h16: ch = "1";
         8'h1E: ch = "2";
         8'h26: ch = "3";
         8'h25: ch = "4";
         8'h2E: ch = "5";
         8'h36: ch = "6";
         8'h3D: ch = "7";
         8'h3E: ch = "8";
         8'h46: ch = "9";
         8'h29: ch = 8'h20;
         8'h5A: ch = 8'h0D;
         default: ch = 8'h00;
      endcase
      if (shift && (ch >= 8'h61) && (ch <= 8'h7A)) begin
         ch = ch - 8'h20;
      end
      return ch;
   endfunction
`else
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_key_t;
`endif

   localparam int unsigned PS2_KEY_W = $bits(ps2_key_t);

endpackage

// File: rtl/ps2_key_fifo.sv
// Show-ahead FIFO for decoded key events. Pointers carry one extra wrap bit so
// full and empty are told apart by the MSB.
module ps2_key_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop on a full FIFO frees the slot the concurrent push lands in.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign rdata = mem[rd_ptr[AW-1:0]];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   // Read/write pointer advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan decoder: frame check, E0/F0 prefix folding, key FIFO.
// Optional feature macro: PS2_ASCII_EN (shift tracking and ASCII output).
module ps2_scan_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_done,
   input  logic [9:0]       frame,
   input  logic             rd_en,
   input  logic             clr_err,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_break,
   output logic [7:0]       ascii,
   output logic             fifo_full,
   output logic             overflow,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   ps2_dec_state_t       state;
   ps2_key_t             new_key;
   ps2_key_t             head;
   logic [PS2_KEY_W-1:0] head_bits;
   logic [7:0]           scan;
   logic                 frame_ok;
   logic                 is_ext;
   logic                 is_brk;
   logic                 push_evt;
   logic                 fifo_empty;
`ifdef PS2_ASCII_EN
   logic                 shift;
`endif

   assign scan     = frame[7:0];
   assign frame_ok = (^frame[8:0]) && frame[9];
   assign is_ext   = (scan == PS2_EXT_CODE);
   assign is_brk   = (scan == PS2_BRK_CODE);
   assign push_evt = frame_done && frame_ok && !is_ext && !is_brk;
   assign head     = ps2_key_t'(head_bits);

   // Assemble the event for the current byte from the pending prefixes.
   always_comb begin
      new_key      = '0;
      new_key.code = scan;
      new_key.ext  = (state == S_EXT) || (state == S_EXT_BRK);
      new_key.brk  = (state == S_BRK) || (state == S_EXT_BRK);
`ifdef PS2_ASCII_EN
      new_key.shift = shift;
`endif
   end

   // Prefix FSM, shift tracking and sticky error/overflow status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         err_cnt  <= '0;
         overflow <= 1'b0;
`ifdef PS2_ASCII_EN
         shift    <= 1'b0;
`endif
      end else begin
         if (frame_done) begin
            if (!frame_ok) begin
               state <= S_IDLE;
            end else if (is_ext) begin
               state <= S_EXT;
            end else if (is_brk) begin
               case (state)
                  S_IDLE:  state <= S_BRK;
                  S_EXT:   state <= S_EXT_BRK;
                  default: state <= state;
               endcase
            end else begin
               state <= S_IDLE;
            end
         end
         if (clr_err) begin
            err_cnt  <= '0;
            overflow <= 1'b0;
         end else begin
            if (frame_done && !frame_ok && (err_cnt != ERR_MAX)) begin
               err_cnt <= err_cnt + ERR_ONE;
            end
            if (push_evt && fifo_full && !rd_en) begin
               overflow <= 1'b1;
            end
         end
`ifdef PS2_ASCII_EN
         // Shift follows the key stream even when the event itself is dropped.
         if (push_evt && ((scan == 8'h12) || (scan == 8'h59))) begin
            shift <= !new_key.brk;
         end
`endif
      end
   end

   ps2_key_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PS2_KEY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_evt),
      .pop   (rd_en),
      .wdata (new_key),
      .rdata (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Show-ahead head entry, forced to zero when the FIFO is empty.
   always_comb begin
      key_valid = !fifo_empty;
      key_code  = 8'h00;
      key_ext   = 1'b0;
      key_break = 1'b0;
      ascii     = 8'h00;
      if (!fifo_empty) begin
         key_code  = head.code;
         key_ext   = head.ext;
         key_break = head.brk;
`ifdef PS2_ASCII_EN
         if (!head.ext && !head.brk) begin
            ascii = ps2_ascii(head.code, head.shift);
         end
`endif
      end
   end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: driver feeds frames into a key-stream
// model that queues expected events; a monitor owns rd_en and checks the head.
module tb_ps2_scan_decoder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned ERR_W = 4;
   localparam int          ERR_SAT = (1 << ERR_W) - 1;

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic [7:0] asc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             frame_done = 1'b0;
   logic [9:0]       frame = 10'h000;
   logic             rd_en = 1'b0;
   logic             clr_err = 1'b0;
   logic             key_valid;
   logic [7:0]       key_code;
   logic             key_ext;
   logic             key_break;
   logic [7:0]       ascii;
   logic             fifo_full;
   logic             overflow;
   logic [ERR_W-1:0] err_cnt;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];
   int   pop_pct = 0;
   bit   mon_on = 1'b0;

   // Reference key-stream state
   bit m_ext = 0;
   bit m_brk = 0;
   bit m_shift = 0;
   bit m_ovf = 0;
   int m_err = 0;

   logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};

   ps2_scan_decoder #(
      .DEPTH (DEPTH),
      .ERR_W (ERR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_done (frame_done),
      .frame      (frame),
      .rd_en      (rd_en),
      .clr_err    (clr_err),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_break  (key_break),
      .ascii      (ascii),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ref_ascii(input logic [7:0] b, input bit prefixed,
                                            input bit shifted);
      logic [7:0] r;
      r = 8'h00;
`ifdef PS2_ASCII_EN
      if (!prefixed) begin
         for (int i = 0; i < 26; i++) begin
            if (letter_codes[i] == b) r = (shifted ? 8'h41 : 8'h61) + 8'(i);
         end
         for (int i = 0; i < 10; i++) begin
            if (digit_codes[i] == b) r = 8'h30 + 8'(i);
         end
         if (b == 8'h29) r = 8'h20;
         if (b == 8'h5A) r = 8'h0D;
      end
`else
      if (prefixed && shifted && b == 8'hFF) r = 8'h00;
`endif
      return r;
   endfunction

   // bad: 0 good frame, 1 parity flipped, 2 stop bit low
   function automatic logic [9:0] mkframe(input logic [7:0] b, input int bad);
      logic par;
      logic stp;
      par = ~(^b);
      stp = 1'b1;
      if (bad == 1) par = ~par;
      if (bad == 2) stp = 1'b0;
      return {stp, par, b};
   endfunction

   // Apply one frame to the reference model (called just before the sampling edge).
   task automatic model_step(input logic [9:0] f, input bit clr);
      exp_t       e;
      logic [7:0] b;
      b = f[7:0];
      if (!((^f[8:0]) && f[9])) begin
         if (m_err < ERR_SAT) m_err++;
         m_ext = 0;
         m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
         m_brk = 0;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         e.code = b;
         e.ext  = m_ext;
         e.brk  = m_brk;
         e.asc  = ref_ascii(b, m_ext || m_brk, m_shift);
         if (exp_q.size() < DEPTH) exp_q.push_back(e);
         else m_ovf = 1;
`ifdef PS2_ASCII_EN
         if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
`endif
         m_ext = 0;
         m_brk = 0;
      end
      if (clr) begin
         m_err = 0;
         m_ovf = 0;
      end
   endtask

   task automatic send(input logic [9:0] f, input bit clr, input int gap);
      @(negedge clk);
      #1;
      frame      = f;
      frame_done = 1'b1;
      clr_err    = clr;
      model_step(f, clr);
      @(negedge clk);
      #1;
      frame_done = 1'b0;
      clr_err    = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      #3;
      rst = 1'b0;
      exp_q.delete();
      m_ext = 0;
      m_brk = 0;
      m_shift = 0;
      m_err = 0;
      m_ovf = 0;
      #1;
      checks++;
      if (key_valid !== 1'b0 || key_code !== 8'h00 || fifo_full !== 1'b0 ||
          overflow !== 1'b0 || err_cnt !== '0) begin
         errors++;
         $display("FAIL async_reset: got valid=%0b code=%h full=%0b ovf=%0b err=%0d, need all 0",
                  key_valid, key_code, fifo_full, overflow, err_cnt);
      end
      @(negedge clk);
      #3;
      rst = 1'b1;
   endtask

   // Monitor: compares head and status every cycle, and decides pops.
   exp_t       hd;
   bit         ev;
   logic [7:0] ec;
   logic [7:0] ea;
   logic       ee;
   logic       eb;
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            ev = (exp_q.size() != 0);
            ec = 8'h00;
            ea = 8'h00;
            ee = 1'b0;
            eb = 1'b0;
            if (ev) begin
               hd = exp_q[0];
               ec = hd.code;
               ea = hd.asc;
               ee = hd.ext;
               eb = hd.brk;
            end
            checks++;
            if (key_valid !== ev || key_code !== ec || key_ext !== ee || key_break !== eb ||
                ascii !== ea) begin
               errors++;
               $display("FAIL head @%0t: got v=%0b code=%h ext=%0b brk=%0b ascii=%h, need v=%0b code=%h ext=%0b brk=%0b ascii=%h",
                        $time, key_valid, key_code, key_ext, key_break, ascii, ev, ec, ee, eb,
                        ea);
            end
            checks++;
            if (fifo_full !== (exp_q.size() == DEPTH) || overflow !== m_ovf ||
                err_cnt !== ERR_W'(m_err)) begin
               errors++;
               $display("FAIL status @%0t: got full=%0b ovf=%0b err=%0d, need full=%0b ovf=%0b err=%0d",
                        $time, fifo_full, overflow, err_cnt, exp_q.size() == DEPTH, m_ovf,
                        m_err);
            end
            rd_en = ($urandom_range(0, 99) < pop_pct);
            if (rd_en && ev) void'(exp_q.pop_front());
         end else begin
            rd_en = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   logic [7:0] rb;
   int         r;
   int         bad;
   initial begin
      // Reset state while rst is held low
      #12;
      checks++;
      if (key_valid !== 1'b0 || key_code !== 8'h00 || key_ext !== 1'b0 ||
          key_break !== 1'b0 || ascii !== 8'h00 || fifo_full !== 1'b0 ||
          overflow !== 1'b0 || err_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: got valid=%0b code=%h full=%0b ovf=%0b err=%0d, need all 0",
                  key_valid, key_code, fifo_full, overflow, err_cnt);
      end
      @(negedge clk);
      #3;
      rst = 1'b1;
      mon_on = 1'b1;

      // Make, break, extended break, bad parity after E0
      send(10'h21C, 0, 2);
      pop_pct = 100; idle(3); pop_pct = 0;
      send(10'h3F0, 0, 2);
      send(10'h21C, 0, 2);
      pop_pct = 100; idle(3); pop_pct = 0;
      send(10'h2E0, 0, 1);
      send(10'h3F0, 0, 1);
      send(10'h374, 0, 2);
      pop_pct = 100; idle(3); pop_pct = 0;
      send(10'h2E0, 0, 1);
      send(10'h31C, 0, 1);
      send(10'h21C, 0, 2);
      pop_pct = 100; idle(3); pop_pct = 0;

      // Overflow: five makes with no reads, then drain in order
      for (int i = 0; i < 5; i++) send(mkframe(letter_codes[i], 0), 0, 1);
      idle(2);
      pop_pct = 100; idle(6); pop_pct = 0;
      // Push while full with a concurrent pop
      for (int i = 0; i < 4; i++) send(mkframe(digit_codes[i], 0), 0, 1);
      pop_pct = 100;
      send(mkframe(8'h29, 0), 0, 0);
      pop_pct = 0;
      idle(2);
      pop_pct = 100; idle(6); pop_pct = 0;

      // Clear with a simultaneous error: clear wins
      send(mkframe(8'h1C, 1), 1, 2);

      // Reset mid-sequence, then with entries queued
      send(10'h2E0, 0, 1);
      do_reset();
      send(10'h21C, 0, 2);
      for (int i = 0; i < 2; i++) send(mkframe(letter_codes[i + 5], 0), 0, 1);
      do_reset();
      idle(2);

      // Error counter saturation
      for (int i = 0; i < 18; i++) send(mkframe(8'h1C, (i % 2) + 1), 0, 0);
      idle(2);
      send(mkframe(8'h24, 0), 1, 1);

      // Randomized key stream with random reading rate
      for (int n = 0; n < 400; n++) begin
         if (n % 40 == 0) pop_pct = $urandom_range(0, 100);
         r = $urandom_range(0, 99);
         if (r < 12) rb = 8'hE0;
         else if (r < 24) rb = 8'hF0;
         else if (r < 34) rb = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
         else if (r < 62) rb = letter_codes[$urandom_range(0, 25)];
         else if (r < 72) rb = digit_codes[$urandom_range(0, 9)];
         else if (r < 76) rb = 8'h29;
         else rb = 8'($urandom);
         bad = ($urandom_range(0, 99) < 5) ? int'($urandom_range(1, 2)) : 0;
         send(mkframe(rb, bad), ($urandom_range(0, 99) < 3), int'($urandom_range(0, 3)));
      end
      pop_pct = 100;
      idle(DEPTH + 3);
      mon_on = 1'b0;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
